// File: rtl/alu_arbiter_if.sv
// Bus bundle between the ALU arbiter, its requesters and the shared ALU.
// slave = arbiter view, master = requester/ALU view.
interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [4*NUM_REQ-1:0]     req_opcode;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_cf;
  logic                     alu_enable;
  logic [WIDTH-1:0]         alu_data_a;
  logic [WIDTH-1:0]         alu_data_b;
  logic [3:0]               alu_opcode;
  logic [WIDTH-1:0]         alu_results;
  logic                     alu_cf;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_results, alu_cf,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_cf,
           alu_enable, alu_data_a, alu_data_b, alu_opcode
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_results, alu_cf,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_cf,
           alu_enable, alu_data_a, alu_data_b, alu_opcode
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters (IDLE->ISSUE->WAIT->RESP).
// Define ALU_ARB_FIXED_PRIORITY_EN for lowest-index-wins fixed priority instead of round-robin.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  alu_arbiter_if.slave  bus
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int unsigned OPW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             cf_q, cf_d, en_q, en_d, rv_q, rv_d;

  logic             gnt_found_c;
  logic [IDW-1:0]   gnt_idx_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic [OPW-1:0]   sel_op_c;
  logic [WIDTH-1:0] sel_a_c, sel_b_c;

  // i-th candidate in search order for the current pointer
  function automatic logic [IDW-1:0] cand(input int unsigned i, input logic [IDW-1:0] ptr);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    cand = IDW'(i);
`else
    cand = IDW'((32'(ptr) + i + 32'd1) % NUM_REQ);
`endif
  endfunction

  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found_c && bus.req_valid[cand(i, ptr_q)]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand(i, ptr_q);
      end
    end
  end

  // payload mux of the winning requester
  always_comb begin
    sel_op_c = '0;
    sel_a_c  = '0;
    sel_b_c  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == gnt_idx_c) begin
        sel_op_c = bus.req_opcode[i*OPW +: OPW];
        sel_a_c  = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_c  = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    if (state_q == IDLE && !RST && gnt_found_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cf_d    = cf_q;
    en_d    = 1'b0;
    rv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found_c) begin
          state_d = ISSUE;
          op_d    = sel_op_c;
          a_d     = sel_a_c;
          b_d     = sel_b_c;
          id_d    = gnt_idx_c;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
          ptr_d   = gnt_idx_c;
`endif
          en_d    = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(ALU_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_d   = bus.alu_results;
          cf_d    = bus.alu_cf;
          rv_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cf_q    <= 1'b0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cf_q    <= cf_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
    end
  end

  assign bus.req_ready  = gnt_c;
  assign bus.alu_enable = en_q;
  assign bus.alu_data_a = a_q;
  assign bus.alu_data_b = b_q;
  assign bus.alu_opcode = op_q;
  assign bus.rsp_valid  = rv_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_cf     = cf_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vectors, corner sequences and randomized traffic
// checked against a transaction-level model (honours ALU_ARB_FIXED_PRIORITY_EN).
module tb_alu_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
  alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .ALU_LAT(1)) dut (.CLK(clk), .RST(rst), .bus(bus));

  // registered ALU: opcode 1 add, opcode 2 subtract (CF = borrow)
  function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd1:    ref_alu = {1'b0, a} + {1'b0, b};
      4'd2:    ref_alu = {1'b0, a} - {1'b0, b};
      default: ref_alu = '0;
    endcase
  endfunction

  logic [W:0] alu_q = '0;
  always @(posedge clk) if (bus.alu_enable) alu_q <= ref_alu(bus.alu_opcode, bus.alu_data_a, bus.alu_data_b);
  assign bus.alu_results = alu_q[W-1:0];
  assign bus.alu_cf      = alu_q[W];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_opcode[i*4 +: 4] = op;
    bus.req_a[i*W +: W]      = a;
    bus.req_b[i*W +: W]      = b;
  endtask

  // bounded wait for any grant; id = -1 on timeout
  task automatic wait_grant(output int id);
    bit got;
    id = -1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        got = 1'b1;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) id = i;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_grant: no req_ready within 20 cycles (cycle %0d)", cyc);
    end
  endtask

  // expected winner from the arbitration rule
  function automatic int pick(input int last, input logic [N-1:0] v);
    pick = -1;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    for (int j = N - 1; j >= 0; j--) if (v[j]) pick = j;
`else
    for (int j = N; j >= 1; j--) if (v[(last + j) % N]) pick = (last + j) % N;
`endif
  endfunction

  typedef struct {
    logic [N-1:0] mask;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           exp_id;
    logic [W-1:0] exp_res;
    logic         exp_cf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int id, prev_cyc, rsp3;
    int last_w, last_g, win, g_id;
    logic [3:0] g_op;
    logic [W-1:0] g_a, g_b;
    logic [W:0] g_ref;
    logic [N-1:0] exp_ready, seen;

    vecs[0] = '{4'b0100, 4'd1, 16'd6464, 16'd4646, 2, 16'd11110, 1'b0};
    vecs[1] = '{4'b0001, 4'd1, 16'hFFFF, 16'h0001, 0, 16'h0000, 1'b1};
    vecs[2] = '{4'b1000, 4'd1, 16'h8000, 16'h8000, 3, 16'h0000, 1'b1};
    vecs[3] = '{4'b0010, 4'd2, 16'd5,    16'd7,    1, 16'hFFFE, 1'b1};
    vecs[4] = '{4'b0001, 4'd1, 16'h1234, 16'h0000, 0, 16'h1234, 1'b0};

    // reset with all four requesting
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, 4'd1, W'(i + 1), 16'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_cf", bus.rsp_cf, 0);
    chk("rst_alu_enable", bus.alu_enable, 0);
    chk("rst_alu_data_a", bus.alu_data_a, 0);
    chk("rst_alu_data_b", bus.alu_data_b, 0);
    chk("rst_alu_opcode", bus.alu_opcode, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // continuous requests: grant order and spacing
    prev_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(id);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      chk("order_id", id, 0);
`else
      chk("order_id", id, g % N);
`endif
      if (g > 0) chk("order_spacing", cyc - prev_cyc, 4);
      prev_cyc = cyc;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (5) @(posedge clk);
    #1;

    // single-requester vectors with full timing
    foreach (vecs[k]) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) set_req(i, 4'($urandom), W'($urandom), W'($urandom));
      set_req(vecs[k].exp_id, vecs[k].op, vecs[k].a, vecs[k].b);
      bus.req_valid = vecs[k].mask;
      wait_grant(id);
      chk("vec_ready", bus.req_ready, vecs[k].mask);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      chk("vec_enable_t1", bus.alu_enable, 1);
      chk("vec_data_a", bus.alu_data_a, vecs[k].a);
      chk("vec_data_b", bus.alu_data_b, vecs[k].b);
      chk("vec_opcode", bus.alu_opcode, vecs[k].op);
      @(negedge clk);
      chk("vec_enable_t2", bus.alu_enable, 0);
      chk("vec_rsp_early", bus.rsp_valid, 0);
      chk("vec_data_a_wait", bus.alu_data_a, vecs[k].a);
      @(negedge clk);
      chk("vec_rsp_valid", bus.rsp_valid, 1);
      chk("vec_rsp_id", bus.rsp_id, vecs[k].exp_id);
      chk("vec_rsp_result", bus.rsp_result, vecs[k].exp_res);
      chk("vec_rsp_cf", bus.rsp_cf, vecs[k].exp_cf);
      @(negedge clk);
      chk("vec_rsp_pulse", bus.rsp_valid, 0);
    end

    // reset during WAIT aborts the operation
    @(posedge clk); #1;
    set_req(2, 4'd1, 16'd100, 16'd200);
    bus.req_valid = 4'b0100;
    wait_grant(id);
    chk("abort_grant", id, 2);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '1;
    @(negedge clk);
    chk("abort_ready_in_rst", bus.req_ready, 0);
    chk("abort_rsp_in_rst", bus.rsp_valid, 0);
    chk("abort_en_in_rst", bus.alu_enable, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_rsp", bus.rsp_valid, 0);
    chk("abort_en_idle", bus.alu_enable, 0);
    chk("abort_next_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("abort_new_issue", bus.alu_enable, 1);
    repeat (4) @(posedge clk);
    #1;

    // requester 1 pulses valid only during WAIT
    set_req(3, 4'd1, 16'd3, 16'd4);
    bus.req_valid = 4'b1000;
    wait_grant(id);
    chk("pulse_grant3", id, 3);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    bus.req_valid = 4'b0010;
    rsp3 = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("pulse_no_ready1", bus.req_ready[1], 0);
      chk("pulse_no_rsp1", bus.rsp_valid && bus.rsp_id == 2'd1, 0);
      if (bus.rsp_valid && bus.rsp_id == 2'd3) rsp3++;
      @(posedge clk); #1;
      bus.req_valid = '0;
    end
    chk("pulse_rsp3_once", rsp3, 1);

    // randomized traffic against the transaction model
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_w = N - 1;
    last_g = -100;
    g_id = 0; g_op = '0; g_a = '0; g_b = '0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      chk("rnd_onehot", $countones(bus.req_ready) <= 1, 1);
      exp_ready = '0;
      win = -1;
      if (k - last_g >= 4 && bus.req_valid != '0) begin
        win = pick(last_w, bus.req_valid);
        exp_ready[win] = 1'b1;
      end
      chk("rnd_ready", bus.req_ready, exp_ready);
      chk("rnd_enable", bus.alu_enable, k == last_g + 1);
      if (k == last_g + 1) begin
        chk("rnd_data_a", bus.alu_data_a, g_a);
        chk("rnd_data_b", bus.alu_data_b, g_b);
        chk("rnd_opcode", bus.alu_opcode, g_op);
      end
      chk("rnd_rsp_valid", bus.rsp_valid, k == last_g + 3);
      if (k == last_g + 3) begin
        g_ref = ref_alu(g_op, g_a, g_b);
        chk("rnd_rsp_id", bus.rsp_id, g_id);
        chk("rnd_rsp_result", bus.rsp_result, g_ref[W-1:0]);
        chk("rnd_rsp_cf", bus.rsp_cf, g_ref[W]);
      end
      if (win >= 0) begin
        g_id = win;
        g_op = bus.req_opcode[win*4 +: 4];
        g_a  = bus.req_a[win*W +: W];
        g_b  = bus.req_b[win*W +: W];
        last_g = k;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
        last_w = win;
`endif
      end
      seen = bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && seen[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 1) == 0);
          if (bus.req_valid[i])
            set_req(i, 4'($urandom_range(1, 2)), ($urandom_range(0, 5) == 0) ? 16'hFFFF : W'($urandom), W'($urandom));
        end else if (bus.req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bus.req_valid[i] = 1'b1;
          set_req(i, 4'($urandom_range(1, 2)), ($urandom_range(0, 5) == 0) ? 16'hFFFF : W'($urandom), W'($urandom));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
